// File: rtl/aes_out_serializer.sv
// -----------------------------------------------------------------------------
// aes_out_serializer
//
// Purpose:
//   Sits after the AES round pipeline. Each 128-bit ciphertext block (a
//   one-cycle i_en pulse) is captured into a small block FIFO. Blocks are then
//   emitted most-significant word first as four 32-bit words on a valid/ready
//   stream. The AES pipeline cannot be stalled, so a block that arrives while
//   the FIFO is full and nothing is leaving is dropped, and o_overflow is set.
//
// Optional build macro:
//   AES_OUT_DROP_CNT_EN - adds o_drop_cnt, a 16-bit saturating count of
//                         dropped blocks.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-low reset
//   i_en         block valid pulse from the AES pipeline
//   i_block      128-bit ciphertext block
//   o_valid      output word valid
//   o_ready      downstream ready
//   o_word       current output word
//   o_last       high with the final (4th) word of a block
//   o_count      blocks waiting in the FIFO (excludes the block being sent)
//   o_full       o_count == FIFO_DEPTH
//   o_overflow   sticky: at least one block was dropped since reset
//   o_drop_cnt   (AES_OUT_DROP_CNT_EN only) saturating drop counter
// -----------------------------------------------------------------------------
module aes_out_serializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int WORD_W     = 32
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                i_en,
  input  logic [127:0]                        i_block,
  output logic                                o_valid,
  input  logic                                o_ready,
  output logic [WORD_W-1:0]                   o_word,
  output logic                                o_last,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_count,
  output logic                                o_full,
  output logic                                o_overflow
`ifdef AES_OUT_DROP_CNT_EN
  ,
  output logic [15:0]                         o_drop_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [127:0]  r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_overflow;
  logic [0:0]    r_state;
  logic [1:0]    r_idx;
  logic [127:0]  r_shift;

  logic          w_last_hs;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_count_nxt;
  logic [127:0]  w_head;
  logic [31:0]   w_word;

  assign w_head = r_mem[r_rd_ptr];

  // Final-word handshake; this is the only point where a sending block ends.
  assign w_last_hs = (r_state == S_SEND) && o_ready && (r_idx == 2'd3);

  // Pops look only at the registered count, so a block written this cycle
  // can never be read back in the same cycle.
  assign w_pop  = (r_count != '0) && ((r_state == S_IDLE) || w_last_hs);
  assign w_push = i_en && ((r_count < DEPTH_C) || w_pop);
  assign w_drop = i_en && !w_push;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Most significant word goes out first.
  always_comb begin
    w_word = r_shift[127:96];
    case (r_idx)
      2'd0: w_word = r_shift[127:96];
      2'd1: w_word = r_shift[95:64];
      2'd2: w_word = r_shift[63:32];
      2'd3: w_word = r_shift[31:0];
      default: w_word = r_shift[127:96];
    endcase
  end

  // Block storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_block;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_state    <= S_IDLE;
      r_idx      <= 2'd0;
      r_shift    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_C);

      // Loading the next block on the last handshake keeps SEND continuous.
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_shift  <= w_head;
        r_idx    <= 2'd0;
        r_state  <= S_SEND;
      end else if ((r_state == S_SEND) && o_ready) begin
        if (r_idx == 2'd3) begin
          r_state <= S_IDLE;
        end else begin
          r_idx <= r_idx + 2'd1;
        end
      end
    end
  end

`ifdef AES_OUT_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign o_drop_cnt = r_drop_cnt;
`endif

  assign o_valid    = (r_state == S_SEND);
  assign o_word     = w_word;
  assign o_last     = (r_state == S_SEND) && (r_idx == 2'd3);
  assign o_count    = r_count;
  assign o_full     = r_full;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_aes_out_serializer.sv
// -----------------------------------------------------------------------------
// tb_aes_out_serializer
//
// Directed bench for aes_out_serializer (FIFO_DEPTH = 4). A table of per-cycle
// stimulus/expectation records covers reset, a single block and back-to-back
// blocks; hand-written sequences cover backpressure, overflow, full FIFO with
// simultaneous push/pop, and reset in the middle of a block.
// -----------------------------------------------------------------------------
module tb_aes_out_serializer;

  logic         clock;
  logic         reset;
  logic         i_en;
  logic [127:0] i_block;
  logic         o_valid;
  logic         o_ready;
  logic [31:0]  o_word;
  logic         o_last;
  logic [2:0]   o_count;
  logic         o_full;
  logic         o_overflow;
`ifdef AES_OUT_DROP_CNT_EN
  logic [15:0]  o_drop_cnt;
`endif

  aes_out_serializer #(.FIFO_DEPTH(4), .WORD_W(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .i_en       (i_en),
    .i_block    (i_block),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_word     (o_word),
    .o_last     (o_last),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_overflow (o_overflow)
`ifdef AES_OUT_DROP_CNT_EN
    ,
    .o_drop_cnt (o_drop_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;

  typedef struct {
    logic         rst_n;
    logic         en;
    logic [127:0] blk;
    logic         rdy;
    logic         e_valid;
    logic [31:0]  e_word;
    logic         e_last;
    logic [2:0]   e_count;
    logic         e_full;
    logic         e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    i_en    = 1'b0;
    i_block = '0;
    step();
    reset = 1'b1;
  endtask

  function automatic vec_t mk(input logic r, input logic en, input logic [127:0] b,
                              input logic rdy, input logic v, input logic [31:0] w,
                              input logic l, input logic [2:0] c, input logic f,
                              input logic o);
    vec_t t;
    t.rst_n = r; t.en = en; t.blk = b; t.rdy = rdy; t.e_valid = v; t.e_word = w;
    t.e_last = l; t.e_count = c; t.e_full = f; t.e_ovf = o;
    return t;
  endfunction

  // Block i: four distinct words i_000000, i_000011, i_000022, i_000033.
  function automatic logic [127:0] mkblk(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, 24'h000000, b, 24'h000011, b, 24'h000022, b, 24'h000033};
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] blk, input int k);
    logic [127:0] sh;
    sh = blk >> (96 - 32 * k);
    return sh[31:0];
  endfunction

  // Accept words with ready held high and compare against blocks first..first+n-1.
  task automatic drain(input string nm, input int first, input int nblk);
    int got;
    got     = 0;
    o_ready = 1'b1;
    i_en    = 1'b0;
    for (int cyc = 0; cyc < nblk * 4 + 20 && got < nblk * 4; cyc++) begin
      if (o_valid) begin
        chk({nm, "_word"}, o_word, word_of(mkblk(first + got / 4), got % 4));
        chk({nm, "_last"}, o_last, (got % 4) == 3);
        got++;
      end
      step();
    end
    chk({nm, "_count_words"}, got, nblk * 4);
    chk({nm, "_idle"}, o_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    reset   = 1'b1;
    i_en    = 1'b0;
    i_block = '0;
    o_ready = 1'b1;

    // ---------------- table-driven: reset, single block, back-to-back --------
    tbl.push_back(mk(0, 0, '0,    1, 0, 32'h0,        0, 0, 0, 0));
    tbl.push_back(mk(0, 1, BLK_A, 1, 0, 32'h0,        0, 0, 0, 0));
    tbl.push_back(mk(1, 1, BLK_A, 1, 0, 32'h0,        0, 1, 0, 0));
    tbl.push_back(mk(1, 0, '0,    1, 1, 32'h00112233, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, '0,    1, 1, 32'h44556677, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, '0,    1, 1, 32'h8899AABB, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, '0,    1, 1, 32'hCCDDEEFF, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, '0,    1, 0, 32'h0,        0, 0, 0, 0));
    tbl.push_back(mk(1, 1, BLK_A, 1, 0, 32'h0,        0, 1, 0, 0));
    tbl.push_back(mk(1, 1, BLK_B, 1, 1, 32'h00112233, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, '0,    1, 1, 32'h44556677, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, '0,    1, 1, 32'h8899AABB, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, '0,    1, 1, 32'hCCDDEEFF, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, '0,    1, 1, 32'hDEADBEEF, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, '0,    1, 1, 32'h01234567, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, '0,    1, 1, 32'h89ABCDEF, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, '0,    1, 1, 32'hFEEDFACE, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, '0,    1, 0, 32'h0,        0, 0, 0, 0));

    for (int r = 0; r < tbl.size(); r++) begin
      reset   = tbl[r].rst_n;
      i_en    = tbl[r].en;
      i_block = tbl[r].blk;
      o_ready = tbl[r].rdy;
      step();
      chk($sformatf("tbl%0d_valid", r), o_valid,    tbl[r].e_valid);
      chk($sformatf("tbl%0d_last",  r), o_last,     tbl[r].e_last);
      chk($sformatf("tbl%0d_count", r), o_count,    tbl[r].e_count);
      chk($sformatf("tbl%0d_full",  r), o_full,     tbl[r].e_full);
      chk($sformatf("tbl%0d_ovf",   r), o_overflow, tbl[r].e_ovf);
      if (tbl[r].e_valid || !tbl[r].rst_n)
        chk($sformatf("tbl%0d_word", r), o_word, tbl[r].e_word);
    end
    reset = 1'b1;

    // ---------------- backpressure ------------------------------------------
    do_reset();
    o_ready = 1'b0;
    i_en = 1'b1; i_block = BLK_A; step();
    i_en = 1'b0; step();
    chk("bp_first_valid", o_valid, 1'b1);
    chk("bp_first_word",  o_word,  32'h00112233);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_stall_valid", o_valid, 1'b1);
      chk("bp_stall_word",  o_word,  32'h00112233);
      chk("bp_stall_last",  o_last,  1'b0);
    end
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      o_ready = (cyc % 2) == 0;
      if (o_valid && o_ready) begin
        chk("bp_word", o_word, word_of(BLK_A, got));
        chk("bp_last", o_last, got == 3);
        got++;
      end
      step();
    end
    chk("bp_words_seen", got, 4);
    chk("bp_idle", o_valid, 1'b0);

    // ---------------- overflow ----------------------------------------------
    do_reset();
    o_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      i_en = 1'b1; i_block = mkblk(k);
      step();
    end
    i_en = 1'b0;
    chk("ovf_count", o_count,    3'd4);
    chk("ovf_full",  o_full,     1'b1);
    chk("ovf_flag",  o_overflow, 1'b1);
    chk("ovf_valid", o_valid,    1'b1);
    chk("ovf_head",  o_word,     word_of(mkblk(1), 0));
`ifdef AES_OUT_DROP_CNT_EN
    chk("ovf_drop_cnt", o_drop_cnt, 16'd1);
`endif
    drain("ovf_drain", 1, 5);
    chk("ovf_sticky", o_overflow, 1'b1);
    chk("ovf_empty",  o_count,    3'd0);

    // ---------------- full FIFO with simultaneous push/pop ------------------
    do_reset();
    o_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      i_en = 1'b1; i_block = mkblk(k);
      step();
    end
    i_en = 1'b0;
    chk("pp_full_before", o_full, 1'b1);
    o_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    chk("pp_last_pending", o_last, 1'b1);
    i_en = 1'b1; i_block = mkblk(6);
    step();
    i_en = 1'b0;
    chk("pp_count", o_count,    3'd4);
    chk("pp_full",  o_full,     1'b1);
    chk("pp_ovf",   o_overflow, 1'b0);
    chk("pp_word",  o_word,     word_of(mkblk(2), 0));
    drain("pp_drain", 2, 5);

    // ---------------- reset mid-block ---------------------------------------
    do_reset();
    o_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      i_en = 1'b1; i_block = mkblk(k);
      step();
    end
    i_en = 1'b0;
    chk("rst_pre_word",  o_word,  word_of(mkblk(1), 1));
    chk("rst_pre_count", o_count, 3'd2);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rst_valid", o_valid,    1'b0);
    chk("rst_count", o_count,    3'd0);
    chk("rst_ovf",   o_overflow, 1'b0);
    chk("rst_full",  o_full,     1'b0);
    chk("rst_word",  o_word,     32'h0);
    i_en = 1'b1; i_block = mkblk(9);
    step();
    i_en = 1'b0;
    chk("rst_n1_valid", o_valid, 1'b0);
    step();
    chk("rst_n2_valid", o_valid, 1'b1);
    drain("rst_new", 9, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_out_serializer.md
Name: aes_out_serializer

Overview:
- Downstream stage of the AES round pipeline: captures each 128-bit ciphertext block (pipeline o_en / enc_val) into a small block FIFO and emits it as four 32-bit words on a valid/ready stream.
- The AES pipeline has no backpressure, so this block absorbs bursts. It reports overflow when a block arrives with no space to store it.

Parameters:
- FIFO_DEPTH, 4, number of 128-bit blocks buffered; power of 2, >= 2
- WORD_W, 32, output word width; fixed at 32 (128/WORD_W = 4 words per block)

Ports:
- clock  input  1  single clock; all logic on the rising edge
- reset  input  1  synchronous, active-low reset
- i_en  input  1  block valid from AES pipeline (one-cycle pulse per block)
- i_block  input  128  ciphertext block (block type)
- o_valid  output  1  output word valid
- o_ready  input  1  downstream ready
- o_word  output  32  current output word
- o_last  output  1  high with the 4th (final) word of a block
- o_count  output  $clog2(FIFO_DEPTH+1)  blocks held in FIFO (excludes the block being serialized)
- o_full  output  1  o_count == FIFO_DEPTH
- o_overflow  output  1  sticky: a block was dropped

Behaviour:
- Reset (reset==0 at a clock edge):
  - Pointers and count go to 0. FSM goes to IDLE. Word index goes to 0.
  - o_valid, o_last, o_full and o_overflow go to 0. o_word goes to 0.
  - Reset mid-block discards the FIFO contents and any partially sent block.
- FIFO:
  - Circular buffer with wr_ptr and rd_ptr, each $clog2(FIFO_DEPTH) bits, wrapping naturally at FIFO_DEPTH.
  - Push happens when i_en==1 and (count < FIFO_DEPTH, or a pop occurs in the same cycle). A full FIFO with a simultaneous pop accepts the push, and the count is unchanged.
  - Drop happens when i_en==1, the FIFO is full and there is no pop in that cycle. The block is discarded, no pointer moves, and o_overflow is set. o_overflow clears only on reset.
  - Simultaneous push and pop leaves the count unchanged and advances both pointers.
- Serializer FSM, states IDLE and SEND:
  - IDLE: if count > 0, pop the head into a 128-bit shift register, set idx = 0 and go to SEND. o_valid = 0.
  - SEND: o_valid = 1 and o_word = shift register bits [127 - 32*idx -: 32], so the most significant word goes first. o_last = (idx == 3).
  - In SEND, when o_valid && o_ready with idx < 3: idx increments.
  - In SEND, when o_valid && o_ready with idx == 3:
    - If count > 0: pop the next block in the same cycle, set idx = 0 and stay in SEND (no bubble between blocks).
    - Otherwise: go to IDLE.
  - o_word and o_last stay stable while o_valid && !o_ready.
  - o_valid never deasserts without a handshake, except on reset.
- Latency:
  - i_en high in cycle N with an empty FIFO in IDLE gives o_valid high in cycle N+2, presenting bits [127:96].
  - With o_ready held at 1, the four words occupy cycles N+2..N+5.
- Throughput: sustained 1 block per 4 cycles with o_ready = 1. A faster AES input rate fills the FIFO.
- Popping uses the registered count, so a block pushed in cycle N is never popped in cycle N.
- o_count and o_full are registered and reflect the state after the last edge.

Optional Feature:
- Macro AES_OUT_DROP_CNT_EN.
- Defined:
  - Adds output port o_drop_cnt (16 bits), reset to 0.
  - Increments on each dropped block and saturates at 16'hFFFF.
  - o_overflow remains.
- Undefined: the port and counter are absent; only the sticky o_overflow reports drops.

Test Plan:
- Single block: reset, then i_en=1 with i_block=128'h00112233_44556677_8899AABB_CCDDEEFF in cycle N, o_ready=1.
  - Required: o_valid in cycles N+2..N+5 with words 00112233, 44556677, 8899AABB, CCDDEEFF.
  - Required: o_last only in N+5, then o_valid=0.
- Backpressure: same block with o_ready=0 for 3 cycles after first o_valid, then toggling 1/0.
  - Required: o_word holds 00112233 while stalled.
  - Required: all 4 words appear exactly once and in order.
- Back-to-back: two blocks A and B on consecutive cycles, o_ready=1.
  - Required: 8 consecutive valid words, A's last word immediately followed by B's first word.
  - Required: o_last in the 4th and 8th cycles.
- Overflow: o_ready=0; push 6 blocks in consecutive cycles with FIFO_DEPTH=4.
  - Required: 1 block in the shift register and 4 in the FIFO (o_full=1, o_count=4).
  - Required: the 6th block is dropped and o_overflow=1 (o_drop_cnt=1 if AES_OUT_DROP_CNT_EN).
  - Required: draining yields blocks 1-5 in order.
- Full with simultaneous push/pop: FIFO full, last-word handshake in the same cycle as i_en.
  - Required: new block accepted, o_count stays 4, o_overflow stays 0.
- Reset mid-operation: assert reset during word 2 of a block with 2 blocks queued.
  - Required: next cycle o_valid=0, o_count=0, o_overflow=0.
  - Required: a subsequent new block serializes normally with N+2 latency.
